rs_data_array_writer: RTL

Write-side controller for the reservation-station data array. It accepts dispatched operand bundles, packs the instruction immediate into operand column 1, and buffers entries in a 2-deep FIFO. It merges a single late-writeback port and drives one write port per operand column of the data array. It is the counterpart of the read-side immediate extractor: that extractor expands stored operand words, and this block produces them.

---
 rtl/rs_data_pkg.sv | 23 ++
 rtl/rs_imm_packer.sv | 34 +++
 rtl/rs_data_array_writer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rs_data_pkg.sv
// Shared types and sizing for the reservation-station data array write path.
package rs_data_pkg;

  localparam int NUM_ENTRIES = 16;
  localparam int XLEN        = 64;
  localparam int ADDR_W      = $clog2(NUM_ENTRIES);
  localparam int DEPTH       = 2;
  localparam int NUM_COLS    = 3;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_U    = 3'd2,
    IMM_Z    = 3'd3
  } imm_type_e;

  typedef struct packed {
    logic [ADDR_W-1:0]                 addr;
    logic [NUM_COLS-1:0]               mask;
    logic [NUM_COLS-1:0][XLEN-1:0]     data;
  } fifo_entry_t;

endpackage

// File: rtl/rs_imm_packer.sv
// Packs the instruction immediate into operand column 1 ahead of the FIFO.
module rs_imm_packer
  import rs_data_pkg::*;
(
  input  logic [2:0]      imm_type,
  input  logic [19:0]     imm,
  input  logic [XLEN-1:0] data_1,
  input  logic [2:0]      mask,
  output logic [XLEN-1:0] packed_data_1,
  output logic [2:0]      packed_mask
);

  always_comb begin
    packed_data_1 = data_1;
    packed_mask   = mask;
    case (imm_type)
      IMM_I: begin
        packed_data_1  = {{(XLEN-12){imm[11]}}, imm[11:0]};
        packed_mask[1] = 1'b1;
      end
      IMM_U: begin
        packed_data_1  = {{(XLEN-32){imm[19]}}, imm, 12'h000};
        packed_mask[1] = 1'b1;
      end
      IMM_Z: begin
        packed_data_1  = {{(XLEN-5){1'b0}}, imm[4:0]};
        packed_mask[1] = 1'b1;
      end
      // reserved encodings leave the bundle untouched
      default: ;
    endcase
  end

endmodule

// File: rtl/rs_data_array_writer.sv
// Write-side controller: 2-deep dispatch FIFO plus a registered late-writeback
// port, arbitrating for one write port per operand column.
module rs_data_array_writer
  import rs_data_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_enq_valid,
  output logic              io_enq_ready,
  input  logic [ADDR_W-1:0] io_enq_bits_addr,
  input  logic [2:0]        io_enq_bits_mask,
  input  logic [XLEN-1:0]   io_enq_bits_data_0,
  input  logic [XLEN-1:0]   io_enq_bits_data_1,
  input  logic [XLEN-1:0]   io_enq_bits_data_2,
  input  logic [2:0]        io_enq_bits_immType,
  input  logic [19:0]       io_enq_bits_imm,
  input  logic              io_wb_valid,
  input  logic [ADDR_W-1:0] io_wb_bits_addr,
  input  logic [1:0]        io_wb_bits_srcIdx,
  input  logic [XLEN-1:0]   io_wb_bits_data,
  output logic              io_write_0_en,
  output logic [ADDR_W-1:0] io_write_0_addr,
  output logic [XLEN-1:0]   io_write_0_data,
  output logic              io_write_1_en,
  output logic [ADDR_W-1:0] io_write_1_addr,
  output logic [XLEN-1:0]   io_write_1_data,
  output logic              io_write_2_en,
  output logic [ADDR_W-1:0] io_write_2_addr,
  output logic [XLEN-1:0]   io_write_2_data,
  output logic [1:0]        io_count,
  output logic              io_empty
);

  fifo_entry_t fifo_q [DEPTH];
  fifo_entry_t fifo_d [DEPTH];
  fifo_entry_t enq_entry;
  fifo_entry_t head;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic              wb_q_valid;
  logic [ADDR_W-1:0] wb_q_addr;
  logic [1:0]        wb_q_src;
  logic [XLEN-1:0]   wb_q_data;

  logic [XLEN-1:0]     packed_data_1;
  logic [2:0]          packed_mask;
  logic [NUM_COLS-1:0] wb_col;
  logic [DEPTH-1:0]    slot_valid;
  logic                enq_fire;
  logic                head_valid;
  logic                conflict;
  logic                pop;
  logic                head_write;

  logic [NUM_COLS-1:0]             col_en;
  logic [NUM_COLS-1:0][ADDR_W-1:0] col_addr;
  logic [NUM_COLS-1:0][XLEN-1:0]   col_data;

  rs_imm_packer u_imm_packer (
    .imm_type      (io_enq_bits_immType),
    .imm           (io_enq_bits_imm),
    .data_1        (io_enq_bits_data_1),
    .mask          (io_enq_bits_mask),
    .packed_data_1 (packed_data_1),
    .packed_mask   (packed_mask)
  );

  // srcIdx 3 decodes to no column, so it neither writes nor forwards
  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      wb_col[c] = wb_q_valid && (wb_q_src == 2'(c));
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_valid[k] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'(k)));
    end
  end

  assign io_enq_ready = (count < 2'(DEPTH));
  assign enq_fire     = io_enq_valid && io_enq_ready;
  assign head         = fifo_q[rd_ptr];
  assign head_valid   = (count != 2'd0);
  assign conflict     = |(head.mask & wb_col);
  assign pop          = head_valid && !conflict;
  assign head_write   = pop && (head.mask != 3'b000);

  always_comb begin
    enq_entry.addr = io_enq_bits_addr;
    enq_entry.mask = packed_mask;
    enq_entry.data = {io_enq_bits_data_2, packed_data_1, io_enq_bits_data_0};
    for (int c = 0; c < NUM_COLS; c++) begin
      if (wb_col[c] && (io_enq_bits_addr == wb_q_addr) && packed_mask[c]) begin
        enq_entry.data[c] = wb_q_data;
      end
    end
  end

  // Stale-overwrite protection: buffered operands pick up the newer writeback
  always_comb begin
    fifo_d = fifo_q;
    for (int k = 0; k < DEPTH; k++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (slot_valid[k] && wb_col[c] && (fifo_q[k].addr == wb_q_addr) && fifo_q[k].mask[c]) begin
          fifo_d[k].data[c] = wb_q_data;
        end
      end
    end
    if (enq_fire) begin
      fifo_d[wr_ptr] = enq_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        fifo_q[k] <= '0;
      end
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      wb_q_valid <= 1'b0;
      wb_q_addr  <= '0;
      wb_q_src   <= 2'd0;
      wb_q_data  <= '0;
    end else begin
      fifo_q     <= fifo_d;
      wb_q_valid <= io_wb_valid;
      wb_q_addr  <= io_wb_bits_addr;
      wb_q_src   <= io_wb_bits_srcIdx;
      wb_q_data  <= io_wb_bits_data;
      if (enq_fire) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      case ({enq_fire, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The head only writes when it has no column in common with wb_q
  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      col_en[c]   = 1'b0;
      col_addr[c] = '0;
      col_data[c] = '0;
      if (wb_col[c]) begin
        col_en[c]   = 1'b1;
        col_addr[c] = wb_q_addr;
        col_data[c] = wb_q_data;
      end else if (head_write && head.mask[c]) begin
        col_en[c]   = 1'b1;
        col_addr[c] = head.addr;
        col_data[c] = head.data[c];
      end
    end
  end

  assign io_write_0_en   = col_en[0];
  assign io_write_0_addr = col_addr[0];
  assign io_write_0_data = col_data[0];
  assign io_write_1_en   = col_en[1];
  assign io_write_1_addr = col_addr[1];
  assign io_write_1_data = col_data[1];
  assign io_write_2_en   = col_en[2];
  assign io_write_2_addr = col_addr[2];
  assign io_write_2_data = col_data[2];
  assign io_count        = count;
  assign io_empty        = (count == 2'd0);

endmodule
